// File: rtl/kvs_query_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : kvs_query_ctrl_if
// Description : Bus bundle for the key-value-store query controller: parser
//               request channel, database request/result channel, packet
//               filter response channel and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface kvs_query_ctrl_if #(
    parameter int KEY_SIZE = 96
);
    // parser -> controller
    logic                req_valid;
    logic                req_ready;
    logic [KEY_SIZE-1:0] req_key;
    logic [3:0]          req_flag;
    logic [7:0]          req_id;
    // controller -> database
    logic [KEY_SIZE-1:0] in_key;
    logic [3:0]          in_flag;
    logic                in_valid;
    // database -> controller
    logic                out_valid;
    logic [3:0]          out_flag;
    // controller -> packet filter
    logic                rsp_valid;
    logic [7:0]          rsp_id;
    logic [3:0]          rsp_flag;
    logic                rsp_timeout;
    // status
    logic [4:0]          outstanding;
    logic [7:0]          err_cnt;

    modport slave (
        input  req_valid, req_key, req_flag, req_id, out_valid, out_flag,
        output req_ready, in_key, in_flag, in_valid,
               rsp_valid, rsp_id, rsp_flag, rsp_timeout, outstanding, err_cnt
    );

    modport master (
        output req_valid, req_key, req_flag, req_id, out_valid, out_flag,
        input  req_ready, in_key, in_flag, in_valid,
               rsp_valid, rsp_id, rsp_flag, rsp_timeout, outstanding, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/kvs_query_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kvs_query_ctrl
// Description : Tracks in-flight key lookups to an in-order database. Tags are
//               queued at request time and retired either by a database
//               result or by an age timeout; results arriving for lookups
//               that already timed out are discarded and counted as errors.
// Revision    : 1.0 - initial release
// ============================================================================
module kvs_query_ctrl #(
    parameter int KEY_SIZE = 96,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    kvs_query_ctrl_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [4:0]          cnt_q,       cnt_d;
    logic [TMR_W-1:0]    timer_q,     timer_d;
    logic [4:0]          stale_q,     stale_d;
    logic [7:0]          err_q,       err_d;
    logic                in_valid_q,  in_valid_d;
    logic [KEY_SIZE-1:0] in_key_q,    in_key_d;
    logic [3:0]          in_flag_q,   in_flag_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_id_q,    rsp_id_d;
    logic [3:0]          rsp_flag_q,  rsp_flag_d;
    logic                rsp_to_q,    rsp_to_d;

    logic [7:0]          tag_mem [DEPTH];

    logic req_ready;
    logic push;
    logic fifo_empty;
    logic ov_stale;
    logic ov_orphan;
    logic pop_result;
    logic pop_timeout;
    logic pop;

    // Retire decisions: a database result always wins over the age timeout;
    // results owed to already timed-out lookups are swallowed first.
    always_comb begin
        req_ready   = (cnt_q < 5'(DEPTH));
        push        = bus.req_valid && req_ready;
        fifo_empty  = (state_q == ST_IDLE);
        ov_stale    = bus.out_valid && (stale_q != 5'd0);
        ov_orphan   = bus.out_valid && (stale_q == 5'd0) && fifo_empty;
        pop_result  = bus.out_valid && (stale_q == 5'd0) && !fifo_empty;
        pop_timeout = !bus.out_valid && !fifo_empty &&
                      (timer_q >= TMR_W'(TIMEOUT - 1));
        pop         = pop_result || pop_timeout;
    end

    // Next-state for queue bookkeeping, FSM, timer, counters and outputs.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        stale_d     = stale_q;
        err_d       = err_q;
        in_valid_d  = push;
        in_key_d    = in_key_q;
        in_flag_d   = in_flag_q;
        rsp_valid_d = pop;
        rsp_id_d    = rsp_id_q;
        rsp_flag_d  = rsp_flag_q;
        rsp_to_d    = rsp_to_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            in_key_d  = bus.req_key;
            in_flag_d = bus.req_flag;
        end

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rsp_id_d   = tag_mem[rd_ptr_q];
            rsp_flag_d = pop_result ? bus.out_flag : 4'd0;
            rsp_to_d   = pop_timeout;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase

        // Timer measures how long the current head has waited.
        if (pop || (push && fifo_empty)) begin
            timer_d = '0;
        end else if (!fifo_empty && (timer_q != {TMR_W{1'b1}})) begin
            timer_d = timer_q + TMR_W'(1);
        end

        if (pop_timeout && (stale_q != 5'h1F)) begin
            stale_d = stale_q + 5'd1;
        end else if (ov_stale) begin
            stale_d = stale_q - 5'd1;
        end

        if ((ov_stale || ov_orphan) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: if (push) state_d = ST_BUSY;
            ST_BUSY: if (cnt_d == 5'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Register all control state; reset drops every in-flight lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= 5'd0;
            timer_q     <= '0;
            stale_q     <= 5'd0;
            err_q       <= 8'd0;
            in_valid_q  <= 1'b0;
            in_key_q    <= '0;
            in_flag_q   <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 8'd0;
            rsp_flag_q  <= 4'd0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            stale_q     <= stale_d;
            err_q       <= err_d;
            in_valid_q  <= in_valid_d;
            in_key_q    <= in_key_d;
            in_flag_q   <= in_flag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_flag_q  <= rsp_flag_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // Tag storage; contents are meaningful only between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= bus.req_id;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.in_valid    = in_valid_q;
    assign bus.in_key      = in_key_q;
    assign bus.in_flag     = in_flag_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_flag    = rsp_flag_q;
    assign bus.rsp_timeout = rsp_to_q;
    assign bus.outstanding = cnt_q;
    assign bus.err_cnt     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_kvs_query_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kvs_query_ctrl
// Description : Directed and randomized bench for kvs_query_ctrl, checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kvs_query_ctrl;

    localparam int KS = 96;
    localparam int DP = 8;
    localparam int TO = 255;
    localparam logic [KS-1:0] KEY_A = 96'h0123_4567_89AB_CDEF_0123_45AB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kvs_query_ctrl_if #(.KEY_SIZE(KS)) bus ();

    kvs_query_ctrl #(
        .KEY_SIZE (KS),
        .DEPTH    (DP),
        .TIMEOUT  (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: queue of waiting tags plus a few counters
    int              mq[$];
    int              m_stale, m_err, m_age;
    logic [KS-1:0]   m_key;
    logic [3:0]      m_flag;
    logic            m_in_v, m_rsp_v, m_rsp_to;
    logic [7:0]      m_rsp_id;
    logic [3:0]      m_rsp_flag;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_stale = 0; m_err = 0; m_age = 0;
        m_key = '0; m_flag = 4'd0;
        m_in_v = 1'b0; m_rsp_v = 1'b0; m_rsp_to = 1'b0;
        m_rsp_id = 8'd0; m_rsp_flag = 4'd0;
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0; bus.req_key = '0; bus.req_flag = 4'd0; bus.req_id = 8'd0;
        bus.out_valid = 1'b0; bus.out_flag = 4'd0;
    endtask

    task automatic check_outputs();
        chk("in_valid",    bus.in_valid,    m_in_v);
        chk("in_key",      bus.in_key,      m_key);
        chk("in_flag",     bus.in_flag,     m_flag);
        chk("outstanding", bus.outstanding, mq.size());
        chk("err_cnt",     bus.err_cnt,     m_err);
        chk("rsp_valid",   bus.rsp_valid,   m_rsp_v);
        if (m_rsp_v) begin
            chk("rsp_id",      bus.rsp_id,      m_rsp_id);
            chk("rsp_flag",    bus.rsp_flag,    m_rsp_flag);
            chk("rsp_timeout", bus.rsp_timeout, m_rsp_to);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic cycle(input logic rv, input logic [KS-1:0] key, input logic [3:0] fl,
                         input logic [7:0] id, input logic ov, input logic [3:0] of);
        bit push, pop, busy;
        bus.req_valid = rv; bus.req_key = key; bus.req_flag = fl; bus.req_id = id;
        bus.out_valid = ov; bus.out_flag = of;
        chk("req_ready", bus.req_ready, mq.size() < DP);
        busy = (mq.size() > 0);
        push = rv && (mq.size() < DP);
        pop  = 1'b0;
        m_rsp_v = 1'b0;
        if (ov) begin
            if (m_stale > 0) begin
                m_stale--;
                if (m_err < 255) m_err++;
            end else if (!busy) begin
                if (m_err < 255) m_err++;
            end else begin
                pop = 1'b1;
                m_rsp_v = 1'b1; m_rsp_id = 8'(mq.pop_front()); m_rsp_flag = of; m_rsp_to = 1'b0;
            end
        end else if (busy && m_age >= TO - 1) begin
            pop = 1'b1;
            m_rsp_v = 1'b1; m_rsp_id = 8'(mq.pop_front()); m_rsp_flag = 4'd0; m_rsp_to = 1'b1;
            if (m_stale < 31) m_stale++;
        end
        if (pop || (push && !busy)) m_age = 0;
        else if (busy) m_age++;
        if (push) begin
            mq.push_back(int'(id));
            m_key = key; m_flag = fl;
        end
        m_in_v = push;
        @(posedge clk); #1;
        check_outputs();
        drive_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive_idle();
        #2;
        chk("rst_in_valid",    bus.in_valid,    1'b0);
        chk("rst_in_key",      bus.in_key,      '0);
        chk("rst_in_flag",     bus.in_flag,     4'd0);
        chk("rst_rsp_valid",   bus.rsp_valid,   1'b0);
        chk("rst_rsp_id",      bus.rsp_id,      8'd0);
        chk("rst_rsp_flag",    bus.rsp_flag,    4'd0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        chk("rst_outstanding", bus.outstanding, 5'd0);
        chk("rst_err_cnt",     bus.err_cnt,     8'd0);
        chk("rst_req_ready",   bus.req_ready,   1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        drive_idle();
        #1;
        reset_dut();

        // single lookup, result three cycles after acceptance
        cycle(1'b1, KEY_A, 4'd1, 8'd5, 1'b0, 4'd0);
        chk("s1_in_valid", bus.in_valid, 1'b1);
        chk("s1_in_key",   bus.in_key,   KEY_A);
        chk("s1_in_flag",  bus.in_flag,  4'd1);
        idle(2);
        cycle(1'b0, '0, 4'd0, 8'd0, 1'b1, 4'd2);
        chk("s1_rsp_valid", bus.rsp_valid,   1'b1);
        chk("s1_rsp_id",    bus.rsp_id,      8'd5);
        chk("s1_rsp_flag",  bus.rsp_flag,    4'd2);
        chk("s1_rsp_to",    bus.rsp_timeout, 1'b0);
        idle(1);
        chk("s1_rsp_once",  bus.rsp_valid,   1'b0);

        // fill to DEPTH, refuse one more, then free one slot
        reset_dut();
        for (int i = 0; i < DP; i++)
            cycle(1'b1, {$urandom, $urandom, $urandom}, 4'(i), 8'(10 + i), 1'b0, 4'd0);
        chk("s2_outstanding", bus.outstanding, 5'd8);
        chk("s2_ready_full",  bus.req_ready,   1'b0);
        cycle(1'b1, KEY_A, 4'd3, 8'd99, 1'b0, 4'd0);
        chk("s2_no_accept",   bus.in_valid,    1'b0);
        cycle(1'b0, '0, 4'd0, 8'd0, 1'b1, 4'd3);
        chk("s2_ready_again", bus.req_ready,   1'b1);
        chk("s2_first_id",    bus.rsp_id,      8'd10);
        for (int i = 1; i < DP; i++) begin
            cycle(1'b0, '0, 4'd0, 8'd0, 1'b1, 4'(i));
            chk("s2_order_id", bus.rsp_id, 8'(10 + i));
        end

        // timeout then late result
        reset_dut();
        cycle(1'b1, KEY_A, 4'd4, 8'd9, 1'b0, 4'd0);
        idle(TO - 1);
        chk("s3_not_yet",      bus.rsp_valid,   1'b0);
        chk("s3_still_out",    bus.outstanding, 5'd1);
        idle(1);
        chk("s3_rsp_valid",    bus.rsp_valid,   1'b1);
        chk("s3_rsp_timeout",  bus.rsp_timeout, 1'b1);
        chk("s3_rsp_flag",     bus.rsp_flag,    4'd0);
        chk("s3_rsp_id",       bus.rsp_id,      8'd9);
        cycle(1'b0, '0, 4'd0, 8'd0, 1'b1, 4'd5);
        chk("s3_late_dropped", bus.rsp_valid,   1'b0);
        chk("s3_err_cnt",      bus.err_cnt,     8'd1);

        // simultaneous push and pop at three outstanding
        reset_dut();
        for (int i = 1; i <= 3; i++) cycle(1'b1, KEY_A, 4'd0, 8'(i), 1'b0, 4'd0);
        cycle(1'b1, KEY_A, 4'd6, 8'd4, 1'b1, 4'd7);
        chk("s4_outstanding", bus.outstanding, 5'd3);
        chk("s4_rsp_id",      bus.rsp_id,      8'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 4'd0, 8'd0, 1'b1, 4'd1);
            chk("s4_order_id", bus.rsp_id, 8'(2 + i));
        end

        // orphan result while idle, then reset with work in flight
        reset_dut();
        cycle(1'b0, '0, 4'd0, 8'd0, 1'b1, 4'd8);
        chk("s5_no_rsp",  bus.rsp_valid, 1'b0);
        chk("s5_err_cnt", bus.err_cnt,   8'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, KEY_A, 4'd2, 8'(20 + i), 1'b0, 4'd0);
        chk("s5_four_out", bus.outstanding, 5'd4);
        reset_dut();
        idle(5);
        chk("s5_silent", bus.rsp_valid, 1'b0);

        // randomized traffic, starting with timed-out lookups owed results
        reset_dut();
        for (int i = 0; i < 3; i++) cycle(1'b1, KEY_A, 4'd1, 8'(40 + i), 1'b0, 4'd0);
        idle(520);
        for (int i = 0; i < 700; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, 4'($urandom),
                  8'($urandom), ($urandom_range(0, 99) < ((i < 350) ? 40 : 10)), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kvs_query_ctrl.md
KVS_QUERY_CTRL -- requirements
Module: kvs_query_ctrl

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 96, lookup key width.
REQ-002 SHALL have parameter DEPTH, default 8, max outstanding lookups (power of 2, 2..16).
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles the oldest lookup may wait before being retired as timed out.
REQ-004 SHALL have port clk  input  1  single clock; all logic in this domain.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  parser offers a lookup.
REQ-007 SHALL have port req_ready  output  1  lookup accepted when req_valid && req_ready.
REQ-008 SHALL have port req_key  input  KEY_SIZE  lookup key.
REQ-009 SHALL have port req_flag  input  4  lookup opcode.
REQ-010 SHALL have port req_id  input  8  packet tag returned with the result.
REQ-011 SHALL have port in_key  output  KEY_SIZE  key to database.
REQ-012 SHALL have port in_flag  output  4  opcode to database.
REQ-013 SHALL have port in_valid  output  1  one-cycle database request strobe.
REQ-014 SHALL have port out_valid  input  1  database result strobe (in request order).
REQ-015 SHALL have port out_flag  input  4  database result.
REQ-016 SHALL have port rsp_valid  output  1  one-cycle result strobe to packet filter.
REQ-017 SHALL have port rsp_id  output  8  tag of retired lookup.
REQ-018 SHALL have port rsp_flag  output  4  database result; 0 on timeout.
REQ-019 SHALL have port rsp_timeout  output  1  retired lookup timed out.
REQ-020 SHALL have port outstanding  output  5  lookups in flight (0..DEPTH).
REQ-021 SHALL have port err_cnt  output  8  saturating count of unexpected or stale results.

Function
REQ-022 SHALL assert req_ready combinationally iff outstanding < DEPTH.
REQ-023 SHALL, on acceptance, drive in_valid=1 with registered in_key/in_flag in the next cycle (latency 1) and push req_id into an in-order tag FIFO.
REQ-024 SHALL hold in_valid=0 otherwise; in_key/in_flag keep last value.
REQ-025 SHALL implement states IDLE (outstanding=0) and BUSY (outstanding>0); IDLE->BUSY on push, BUSY->IDLE when the last entry retires with no simultaneous push.
REQ-026 SHALL, on out_valid with stale=0 and FIFO non-empty, pop the head and next cycle emit rsp_valid=1, rsp_id=head, rsp_flag=out_flag, rsp_timeout=0.
REQ-027 SHALL run an age timer: cleared on every pop and on empty->non-empty, incremented each BUSY cycle.
REQ-028 SHALL, when the timer reaches TIMEOUT-1 without out_valid, pop the head, emit rsp_valid=1, rsp_id=head, rsp_flag=0, rsp_timeout=1 next cycle, and increment a 5-bit stale counter.
REQ-029 SHALL, on out_valid while stale>0, discard the result, decrement stale, increment err_cnt, and not pop the FIFO.
REQ-030 SHALL, on out_valid with stale=0 and FIFO empty, discard and increment err_cnt.
REQ-031 SHALL give out_valid priority over timeout in the same cycle (normal retire, timer cleared).
REQ-032 SHALL leave outstanding unchanged on simultaneous push and pop; the FIFO pointers wrap modulo DEPTH.
REQ-033 SHALL saturate err_cnt at 255.
REQ-034 SHALL emit at most one rsp_valid per cycle; the latency from out_valid to rsp_valid is exactly 1.

Reset
REQ-035 SHALL, while rst_n=0, force state=IDLE, FIFO empty, timer=0, stale=0, err_cnt=0, in_valid=0, in_key=0, in_flag=0, rsp_valid=0, rsp_id=0, rsp_flag=0, rsp_timeout=0, outstanding=0.
REQ-036 SHALL, when reset is asserted mid-operation, drop all in-flight lookups without emitting rsp_valid.

Verification
REQ-037 SHALL cover: one request key=0x0123..AB, flag=1, id=5; out_valid flag=2 three cycles later -> in_valid one cycle after accept; rsp_valid with id=5, flag=2, timeout=0 one cycle after out_valid.
REQ-038 SHALL cover: 8 back-to-back requests, no results -> req_ready=0 after the eighth, outstanding=8; one result -> req_ready=1 next cycle.
REQ-039 SHALL cover: one request, no result for TIMEOUT cycles -> rsp_valid, rsp_timeout=1, rsp_flag=0; a late out_valid -> discarded, err_cnt=1, no rsp_valid.
REQ-040 SHALL cover: push and out_valid in the same cycle at outstanding=3 -> outstanding stays 3; ids retire in order.
REQ-041 SHALL cover: out_valid while idle -> no rsp_valid, err_cnt=1; rst_n pulsed with 4 outstanding -> all outputs 0, no rsp_valid afterwards.
